s2p_deser: RTL and testbench
============================

S2P_DESER -- requirements
Module: s2p_deser

Interface
REQ-001 SHALL have parameter W, default 16, parallel word width in bits (legal 2..64).
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = first serial bit lands in y[W-1], 0 = first bit lands in y[0].
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-005 SHALL have port a, input, 1, serial data bit.
REQ-006 SHALL have port en, input, 1, bit-valid; a is sampled only on edges where en=1.
REQ-007 SHALL have port clr, input, 1, synchronous clear of the partial word.
REQ-008 SHALL have port ack, input, 1, consumer acknowledges the held word.
REQ-009 SHALL have port y, output, W, last completed parallel word, held stable.
REQ-010 SHALL have port vld, output, 1, y holds an unacknowledged word.
REQ-011 SHALL have port ovf, output, 1, sticky flag: a completed word was dropped.
REQ-012 SHALL have port cnt, output, $clog2(W), number of bits collected in the current partial word.

Function
REQ-013 SHALL keep an internal shift register sh (W bits) and a bit counter cnt running 0..W-1.
REQ-014 SHALL, on an edge with en=1 and clr=0, shift a into sh: toward MSB when MSB_FIRST=1 (new bit enters sh[0]), toward LSB when MSB_FIRST=0 (new bit enters sh[W-1]), and increment cnt.
REQ-015 SHALL, on an edge with en=0 and clr=0, hold sh and cnt.
REQ-016 SHALL treat the edge where en=1 and cnt=W-1 as word completion: the completed word is {sh shifted with the current a}; cnt wraps to 0 on the same edge.
REQ-017 SHALL, at completion with vld=0 or ack=1, load y with the completed word and set vld=1 on that same edge (latency: y/vld valid one edge after the W-th bit is sampled).
REQ-018 SHALL, at completion with vld=1 and ack=0, leave y unchanged, keep vld=1, discard the completed word, and set ovf=1.
REQ-019 SHALL clear vld on an edge with ack=1 when no completion occurs on that edge; ack while vld=0 has no effect.
REQ-020 SHALL hold y unchanged at all times except per REQ-017; y is never partially updated.
REQ-021 SHALL, on an edge with clr=1, set cnt=0, sh=0 and ovf=0, discarding any partial word and ignoring en/a on that edge; y and vld are unaffected and ack is still honoured.
REQ-022 SHALL keep ovf set until clr or reset.
REQ-023 SHALL allow back-to-back words: en=1 continuously yields one completion every W edges with no lost bit.

Reset
REQ-024 SHALL, while rst_n=0, immediately force sh=0, cnt=0, y=0, vld=0, ovf=0 regardless of clk.
REQ-025 SHALL, on reset mid-word, discard the partial word; the first en=1 edge after rst_n rises is bit 0 of a new word.
REQ-026 SHALL ignore en, clr and ack on any edge while rst_n=0.

Verification (W=8)
REQ-027 SHALL verify MSB_FIRST=1: bits 1,0,1,0,0,1,0,1 on 8 consecutive en edges -> y=8'hA5, vld=1 after 8th edge, cnt back to 0.
REQ-028 SHALL verify MSB_FIRST=0: same bit stream -> y=8'hA5 bit-reversed = 8'hA5 replaced by stream 1,1,0,0,0,0,0,0 -> y=8'h03.
REQ-029 SHALL verify en gaps: 8'h3C sent with en low every other cycle -> y=8'h3C, cnt increments only on en edges.
REQ-030 SHALL verify overflow: word 8'h11 unacked, then 8'h22 completes -> y stays 8'h11, vld=1, ovf=1; ack then next word 8'h33 -> y=8'h33, ovf still 1 until clr.
REQ-031 SHALL verify ack coincident with completion: vld=1 holding 8'h11, ack=1 on the completing edge of 8'h44 -> y=8'h44, vld=1, ovf=0.
REQ-032 SHALL verify reset/clear mid-word: 4 bits sent, rst_n pulsed low asynchronously between edges -> y=0, vld=0, cnt=0 immediately; repeat with clr=1 -> cnt=0, y/vld unchanged, next 8 bits form a clean word.

Source files
------------

// File: rtl/s2p_deser.sv
// Serial-to-parallel deserializer: collects W bits on en-qualified edges into a held
// output word with valid/acknowledge handshake and a sticky overflow flag.
module s2p_deser #(
    parameter int W         = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 ack,
    output logic [W-1:0]         y,
    output logic                 vld,
    output logic                 ovf,
    output logic [$clog2(W)-1:0] cnt
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    logic [W-1:0]  r_sh;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_y;
    logic          r_vld;
    logic          r_ovf;

    logic [W-1:0]  w_shifted;
    logic          w_complete;
    logic          w_load;
    logic          w_drop;

    // The completed word is the shift register already including the current bit,
    // so y can be loaded on the same edge the last bit is sampled.
    always_comb begin
        w_shifted  = '0;
        if (MSB_FIRST) begin
            w_shifted = {r_sh[W-2:0], a};
        end else begin
            w_shifted = {a, r_sh[W-1:1]};
        end
        w_complete = en && !clr && (r_cnt == LAST_BIT);
        w_load     = w_complete && (!r_vld || ack);
        w_drop     = w_complete && r_vld && !ack;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (clr) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (en) begin
            r_sh  <= w_shifted;
            r_cnt <= w_complete ? '0 : r_cnt + CW'(1);
        end
    end

    // Completion wins over ack; a lone ack releases the held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y   <= '0;
            r_vld <= 1'b0;
        end else if (w_load) begin
            r_y   <= w_shifted;
            r_vld <= 1'b1;
        end else if (ack && !w_complete) begin
            r_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (clr) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    assign y   = r_y;
    assign vld = r_vld;
    assign ovf = r_ovf;
    assign cnt = r_cnt;

endmodule

// File: tb/tb_s2p_deser.sv
// Self-checking bench for s2p_deser: one MSB-first and one LSB-first instance share
// the stimulus and are compared against a bit-queue reference model.
module tb_s2p_deser;

    localparam int W  = 8;
    localparam int CW = $clog2(W);

    logic          clk;
    logic          rst_n;
    logic          a;
    logic          en;
    logic          clr;
    logic          ack;
    logic [W-1:0]  yMsb;
    logic [W-1:0]  yLsb;
    logic          vldMsb;
    logic          vldLsb;
    logic          ovfMsb;
    logic          ovfLsb;
    logic [CW-1:0] cntMsb;
    logic [CW-1:0] cntLsb;

    int errorCount = 0;
    int checkCount = 0;

    // Reference model state
    bit           modelBits[$];
    logic [W-1:0] modelYMsb;
    logic [W-1:0] modelYLsb;
    logic         modelVld;
    logic         modelOvf;

    s2p_deser #(.W(W), .MSB_FIRST(1'b1)) dutMsb (
        .clk(clk), .rst_n(rst_n), .a(a), .en(en), .clr(clr), .ack(ack),
        .y(yMsb), .vld(vldMsb), .ovf(ovfMsb), .cnt(cntMsb)
    );

    s2p_deser #(.W(W), .MSB_FIRST(1'b0)) dutLsb (
        .clk(clk), .rst_n(rst_n), .a(a), .en(en), .clr(clr), .ack(ack),
        .y(yLsb), .vld(vldLsb), .ovf(ovfLsb), .cnt(cntLsb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        modelBits.delete();
        modelYMsb = '0;
        modelYLsb = '0;
        modelVld  = 1'b0;
        modelOvf  = 1'b0;
    endtask

    // First received bit is the MSB for the MSB-first instance and the LSB otherwise.
    task automatic modelStep(input logic stepEn, input logic stepA,
                             input logic stepClr, input logic stepAck);
        logic [W-1:0] wordMsb;
        logic [W-1:0] wordLsb;
        bit           completed;
        completed = 1'b0;
        if (stepClr) begin
            modelBits.delete();
            modelOvf = 1'b0;
        end else if (stepEn) begin
            modelBits.push_back(stepA);
            if (modelBits.size() == W) begin
                completed = 1'b1;
                wordMsb   = '0;
                wordLsb   = '0;
                for (int i = 0; i < W; i++) begin
                    wordMsb[W-1-i] = modelBits[i];
                    wordLsb[i]     = modelBits[i];
                end
                modelBits.delete();
                if (!modelVld || stepAck) begin
                    modelYMsb = wordMsb;
                    modelYLsb = wordLsb;
                    modelVld  = 1'b1;
                end else begin
                    modelOvf = 1'b1;
                end
            end
        end
        if (!completed && stepAck) modelVld = 1'b0;
    endtask

    task automatic checkAll();
        checkOutput("yMsb", yMsb, modelYMsb);
        checkOutput("yLsb", yLsb, modelYLsb);
        checkOutput("vldMsb", vldMsb, modelVld);
        checkOutput("vldLsb", vldLsb, modelVld);
        checkOutput("ovfMsb", ovfMsb, modelOvf);
        checkOutput("ovfLsb", ovfLsb, modelOvf);
        checkOutput("cntMsb", cntMsb, modelBits.size());
        checkOutput("cntLsb", cntLsb, modelBits.size());
    endtask

    // Drives one cycle of inputs, advances the model, then samples 1 ns after the edge.
    task automatic applyStimulus(input logic stepEn, input logic stepA,
                                 input logic stepClr, input logic stepAck);
        en  = stepEn;
        a   = stepA;
        clr = stepClr;
        ack = stepAck;
        if (rst_n) modelStep(stepEn, stepA, stepClr, stepAck);
        @(posedge clk);
        #1;
        checkAll();
    endtask

    task automatic sendWord(input logic [W-1:0] value, input bit gaps, input logic ackLast);
        for (int i = W - 1; i >= 0; i--) begin
            if (gaps) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            applyStimulus(1'b1, value[i], 1'b0, (i == 0) ? ackLast : 1'b0);
        end
    endtask

    task automatic asyncReset();
        #2 rst_n = 1'b0;
        modelReset();
        #1;
        checkAll();
        #2 rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] patA5;
        logic [W-1:0] patC0;
        rst_n = 1'b0;
        a     = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        ack   = 1'b0;
        modelReset();

        // Edges during reset must be ignored
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("resetCnt", cntMsb, 0);
        checkOutput("resetVld", vldMsb, 0);
        #2 rst_n = 1'b1;

        patA5 = 8'hA5;
        sendWord(patA5, 1'b0, 1'b0);
        checkOutput("msbA5", yMsb, 8'hA5);
        checkOutput("lsbA5", yLsb, 8'hA5);
        checkOutput("vldA5", vldMsb, 1'b1);
        checkOutput("cntWrap", cntMsb, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("ackClears", vldMsb, 1'b0);

        patC0 = 8'hC0;
        sendWord(patC0, 1'b0, 1'b1);
        checkOutput("lsb03", yLsb, 8'h03);
        checkOutput("msbC0", yMsb, 8'hC0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        sendWord(8'h3C, 1'b1, 1'b0);
        checkOutput("gaps3C", yMsb, 8'h3C);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        // Overflow: second word dropped while first unacknowledged
        sendWord(8'h11, 1'b0, 1'b0);
        sendWord(8'h22, 1'b0, 1'b0);
        checkOutput("ovfHold", yMsb, 8'h11);
        checkOutput("ovfVld", vldMsb, 1'b1);
        checkOutput("ovfSet", ovfMsb, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        sendWord(8'h33, 1'b0, 1'b0);
        checkOutput("after33", yMsb, 8'h33);
        checkOutput("ovfSticky", ovfMsb, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("clrOvf", ovfMsb, 1'b0);
        checkOutput("clrKeepsVld", vldMsb, 1'b1);

        // Ack on the completing edge replaces the held word without overflow
        sendWord(8'h44, 1'b0, 1'b1);
        checkOutput("coincY", yMsb, 8'h44);
        checkOutput("coincVld", vldMsb, 1'b1);
        checkOutput("coincOvf", ovfMsb, 1'b0);

        // Async reset mid-word
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        asyncReset();
        checkOutput("rstY", yMsb, 0);
        checkOutput("rstCnt", cntMsb, 0);
        sendWord(8'h5A, 1'b0, 1'b0);
        checkOutput("postRst", yMsb, 8'h5A);

        // Clear mid-word keeps y/vld and restarts word assembly
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("clrCnt", cntMsb, 0);
        checkOutput("clrY", yMsb, 8'h5A);
        checkOutput("clrVld", vldMsb, 1'b1);
        sendWord(8'h96, 1'b0, 1'b1);
        checkOutput("clrClean", yMsb, 8'h96);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                asyncReset();
            end else begin
                applyStimulus($urandom_range(0, 9) < 7, 1'($urandom),
                              $urandom_range(0, 99) < 3, $urandom_range(0, 4) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
